mult_div_unit: RTL and testbench
================================

# mult_div_unit

Parametrised multicycle multiply/divide unit for the multicycle MIPS datapath, implementing mult, multu, div and divu with architectural HI/LO registers. The control unit issues an operation with a start pulse, holds in a wait state while busy is high, and resumes on done. A divide-by-zero flag is raised alongside done so the control unit can take the exception path (EPC capture) the same way it handles ALU Overflow.

## Interface
Parameters:
- WIDTH, 32: operand width. HI and LO are WIDTH bits each; the iteration count is WIDTH.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; clears all state
- start  in  1  request; sampled only in IDLE
- op  in  2  00 mult, 01 multu, 10 div, 11 divu
- a  in  WIDTH  operand A (rs, RegA output); captured at accept
- b  in  WIDTH  operand B (rt, RegB output); captured at accept
- busy  out  1  high in MULT/DIV states
- done  out  1  single-cycle pulse; HI/LO valid in the same cycle
- div_zero  out  1  single-cycle pulse, coincident with done, for div/divu with b==0
- hi  out  WIDTH  HI register (upper product / remainder)
- lo  out  WIDTH  LO register (lower product / quotient)

## Operation
- States: IDLE, MULT, DIV, DONE.
- Transitions:
  - IDLE→MULT on start with op[1]=0.
  - IDLE→DIV on start with op[1]=1 and b≠0.
  - IDLE→DONE on start with op[1]=1 and b==0 (div_zero case).
  - MULT/DIV→DONE after WIDTH iterations.
  - DONE→IDLE unconditionally.
- Accept: capture op, |a| and |b| (magnitudes if signed, raw if unsigned), sign bits, and clear a log2(WIDTH)+1-bit iteration counter.
- MULT: one shift-add step per cycle on a 2·WIDTH accumulator. On the final step, negate the product if sa^sb (signed only). Write {hi,lo} ← product.
- DIV: one restoring step per cycle (shift remainder/quotient left, trial subtract, restore on negative).
  - Final step: lo ← quotient, hi ← remainder.
  - Signed sign fix: quotient negated if sa^sb; remainder takes the sign of a.
- Signed div of the most negative value by -1: lo = 0x80…0 (two's-complement wrap), hi = 0. No flag.
- Div by zero: hi/lo are left unchanged; done=1 and div_zero=1 for one cycle.
- start is ignored in MULT, DIV and DONE; there is no queueing.
- Operand inputs may change freely after the accept cycle.
- Arithmetic is all modulo 2·WIDTH internally. Products are exact, with no overflow indication.

## Timing
- Reset values: state=IDLE, busy=0, done=0, div_zero=0, hi=0, lo=0, counter=0.
- Reset asserted mid-operation aborts immediately and asynchronously. hi/lo go to 0 and the partial result is discarded.
- start high in IDLE at cycle 0 gives:
  - busy=1 in cycles 1..WIDTH;
  - done=1 in cycle WIDTH+1, with hi/lo updated on the edge entering that cycle;
  - back in IDLE in cycle WIDTH+2, where a new start is accepted.
- Div by zero: done=div_zero=1 in cycle 1. busy is never asserted.
- Back-to-back throughput: one operation per WIDTH+2 cycles.
- busy, done and div_zero are registered state decodes with no combinational path from inputs.

## Configuration
- MULTDIV_SIGNED_EN defined:
  - op[0]=0 selects signed operation with full sign handling, as in Operation.
  - Magnitude conversion and sign-fix logic are compiled in.
- Not defined:
  - op[0] is ignored and all operations are unsigned (mult≡multu, div≡divu).
  - Sign logic is removed.
  - The most-negative ÷ -1 case does not exist.

## Test plan
- multu a=0xFFFFFFFF, b=0xFFFFFFFF (WIDTH=32) → done at cycle 33; hi=0xFFFFFFFE, lo=0x00000001; busy high cycles 1–32 exactly.
- mult a=0xFFFFFFFD (−3), b=5 with MULTDIV_SIGNED_EN → hi=0xFFFFFFFF, lo=0xFFFFFFF1. Without the macro → hi=0x00000004, lo=0xFFFFFFF1.
- div a=0xFFFFFFF9 (−7), b=2 signed → lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu a=100, b=7 → lo=14, hi=2.
- divu a=100, b=0 with hi/lo preloaded 5/6 → done=div_zero=1 at cycle 1, busy never high, hi=5, lo=6. Signed div a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- start re-pulsed at cycle 5 of a multu → ignored, result unchanged, done still at cycle 33. start held high continuously → operations accepted every 34 cycles.
- reset driven low at cycle 10 of a div → busy=0, hi=lo=0 immediately without a clock edge. After release, a fresh multu 3×4 gives lo=12, hi=0.

Source files
------------

// File: rtl/mult_div_unit.sv
// Multicycle multiply/divide unit with architectural HI/LO for the MIPS datapath.
// Optional signed support (mult/div) is compiled in with MULTDIV_SIGNED_EN.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
   localparam logic [CW-1:0] ONE_CNT  = {{(CW-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE = 2'd0, MULT = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;

   state_t             state_r, state_s;
   logic [2*WIDTH-1:0] p_r;
   logic [WIDTH-1:0]   d_r, hi_r, lo_r;
   logic [CW-1:0]      cnt_r;
   logic               busy_r, done_r, dz_r;
   logic               accept_s, last_s, b_zero_s;
   logic [WIDTH-1:0]   ma_s, mb_s;
   logic [WIDTH:0]     mul_sum_s;
   logic [2*WIDTH-1:0] mul_next_s, div_next_s, mres_s;
   logic [WIDTH+1:0]   div_diff_s;
   logic               div_neg_s;
   logic [WIDTH-1:0]   qres_s, rres_s;

   assign accept_s = (state_r == IDLE) && start;
   assign last_s   = (cnt_r == LAST_CNT);
   assign b_zero_s = (b == {WIDTH{1'b0}});

`ifdef MULTDIV_SIGNED_EN
   localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
      return (~v) + ONE_W;
   endfunction

   function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
      return (~v) + ONE_2W;
   endfunction

   logic sgn_s, sa_s, sb_s, neg_r, sa_r;
   assign sgn_s = ~op[0];
   assign sa_s  = sgn_s & a[WIDTH-1];
   assign sb_s  = sgn_s & b[WIDTH-1];
   assign ma_s  = sa_s ? neg_w(a) : a;
   assign mb_s  = sb_s ? neg_w(b) : b;

   // Operand signs captured at accept for the final sign fix
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         neg_r <= 1'b0;
         sa_r  <= 1'b0;
      end else if (accept_s) begin
         neg_r <= sa_s ^ sb_s;
         sa_r  <= sa_s;
      end
   end
`else
   logic unused_op0_s;
   assign unused_op0_s = op[0];
   assign ma_s = a;
   assign mb_s = b;
`endif

   // Shift-add step: low half holds the remaining multiplier bits
   assign mul_sum_s  = {1'b0, p_r[2*WIDTH-1:WIDTH]} + (p_r[0] ? {1'b0, d_r} : {(WIDTH+1){1'b0}});
   assign mul_next_s = {mul_sum_s, p_r[WIDTH-1:1]};

   // Restoring step: {remainder, quotient} shifted left, trial subtract of divisor
   assign div_diff_s = {1'b0, p_r[2*WIDTH-1:WIDTH], p_r[WIDTH-1]} - {2'b00, d_r};
   assign div_neg_s  = div_diff_s[WIDTH+1];
   assign div_next_s = {(div_neg_s ? {p_r[2*WIDTH-2:WIDTH], p_r[WIDTH-1]} : div_diff_s[WIDTH-1:0]),
                        p_r[WIDTH-2:0], ~div_neg_s};

   // Final result selection including the signed correction
   always_comb begin
      mres_s = mul_next_s;
      qres_s = div_next_s[WIDTH-1:0];
      rres_s = div_next_s[2*WIDTH-1:WIDTH];
`ifdef MULTDIV_SIGNED_EN
      if (neg_r) begin
         mres_s = neg_2w(mul_next_s);
         qres_s = neg_w(div_next_s[WIDTH-1:0]);
      end else begin
         mres_s = mul_next_s;
         qres_s = div_next_s[WIDTH-1:0];
      end
      if (sa_r) begin
         rres_s = neg_w(div_next_s[2*WIDTH-1:WIDTH]);
      end else begin
         rres_s = div_next_s[2*WIDTH-1:WIDTH];
      end
`endif
   end

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (!start) begin
               state_s = IDLE;
            end else if (!op[1]) begin
               state_s = MULT;
            end else if (b_zero_s) begin
               state_s = DONE;
            end else begin
               state_s = DIV;
            end
         end
         MULT, DIV: begin
            if (last_s) begin
               state_s = DONE;
            end else begin
               state_s = state_r;
            end
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State register and registered status decodes
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         dz_r    <= 1'b0;
      end else begin
         state_r <= state_s;
         busy_r  <= (state_s == MULT) || (state_s == DIV);
         done_r  <= (state_s == DONE);
         dz_r    <= accept_s && op[1] && b_zero_s;
      end
   end

   // Datapath: operand capture, iteration and HI/LO writeback
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         p_r   <= {(2*WIDTH){1'b0}};
         d_r   <= {WIDTH{1'b0}};
         cnt_r <= {CW{1'b0}};
         hi_r  <= {WIDTH{1'b0}};
         lo_r  <= {WIDTH{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  d_r   <= op[1] ? mb_s : ma_s;
                  p_r   <= {{WIDTH{1'b0}}, (op[1] ? ma_s : mb_s)};
                  cnt_r <= {CW{1'b0}};
               end
            end
            MULT: begin
               p_r   <= mul_next_s;
               cnt_r <= cnt_r + ONE_CNT;
               if (last_s) begin
                  {hi_r, lo_r} <= mres_s;
               end
            end
            DIV: begin
               p_r   <= div_next_s;
               cnt_r <= cnt_r + ONE_CNT;
               if (last_s) begin
                  hi_r <= rres_s;
                  lo_r <= qres_s;
               end
            end
            default: begin
               cnt_r <= cnt_r;
            end
         endcase
      end
   end

   assign busy     = busy_r;
   assign done     = done_r;
   assign div_zero = dz_r;
   assign hi       = hi_r;
   assign lo       = lo_r;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed table, timing corner sequences
// and randomized operations against an arithmetic reference model.
module tb_mult_div_unit;
   localparam int W = 32;

   logic          clock = 1'b0;
   logic          reset, start;
   logic [1:0]    op;
   logic [W-1:0]  a, b;
   logic          busy, done, div_zero;
   logic [W-1:0]  hi, lo;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_hi = '0;
   logic [W-1:0] exp_lo = '0;

   mult_div_unit #(.WIDTH(W)) dut (
      .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] ehi;
      logic [W-1:0] elo;
      logic         edz;
   } vec_t;

   vec_t tbl[11];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // Plain arithmetic reference: returns {div_zero, hi, lo}
   function automatic logic [2*W:0] ref_model(input logic [1:0] o, input logic [W-1:0] av, bv,
                                                input logic [W-1:0] phi, plo);
      bit sg;
      longint va, vb, p, q, r;
`ifdef MULTDIV_SIGNED_EN
      sg = !o[0];
`else
      sg = 1'b0;
`endif
      va = sg ? longint'(signed'(av)) : longint'({32'd0, av});
      vb = sg ? longint'(signed'(bv)) : longint'({32'd0, bv});
      if (!o[1]) begin
         p = va * vb;
         return {1'b0, p[63:32], p[31:0]};
      end else if (bv == '0) begin
         return {1'b1, phi, plo};
      end else begin
         q = va / vb;
         r = va % vb;
         return {1'b0, r[31:0], q[31:0]};
      end
   endfunction

   task automatic run_op(input string nm, input logic [1:0] o, input logic [W-1:0] av, bv,
                         input logic [W-1:0] ehi, elo, input logic edz, input int repulse);
      int dcyc = 0;
      int ndone = 0;
      int bad_busy = 0;
      int ndz = 0;
      logic [W-1:0] hs = '0;
      logic [W-1:0] ls = '0;
      @(negedge clock);
      op = o; a = av; b = bv; start = 1'b1;
      for (int c = 1; c <= W + 3; c++) begin
         @(negedge clock);
         if (c == 1) begin
            a = $urandom; b = $urandom;
         end
         if (c == repulse) begin
            start = 1'b1; op = ~o; a = $urandom; b = $urandom;
         end else begin
            start = 1'b0;
         end
         if (busy !== (!edz && c <= W)) bad_busy++;
         if (done === 1'b1) begin
            ndone++; dcyc = c; hs = hi; ls = lo;
         end
         if (div_zero === 1'b1) begin
            if (done === 1'b1) ndz++;
            else ndz += 10;
         end
      end
      chk($sformatf("%s.done_cycle", nm), 64'(dcyc), 64'(edz ? 1 : W + 1));
      chk($sformatf("%s.done_count", nm), 64'(ndone), 64'd1);
      chk($sformatf("%s.busy_window", nm), 64'(bad_busy), 64'd0);
      chk($sformatf("%s.div_zero", nm), 64'(ndz), 64'(edz ? 1 : 0));
      chk($sformatf("%s.hi", nm), 64'(hs), 64'(ehi));
      chk($sformatf("%s.lo", nm), 64'(ls), 64'(elo));
      exp_hi = ehi;
      exp_lo = elo;
   endtask

   initial begin
      logic [2*W:0] res;
      int dc[3];
      int nd;
      logic [1:0] ro;
      logic [W-1:0] ra, rb;

      tbl[0] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
`ifdef MULTDIV_SIGNED_EN
      tbl[1] = '{2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
      tbl[2] = '{2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
      tbl[6] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
      tbl[10] = '{2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0};
`else
      tbl[1] = '{2'b00, 32'hFFFFFFFD, 32'd5, 32'h00000004, 32'hFFFFFFF1, 1'b0};
      tbl[2] = '{2'b10, 32'hFFFFFFF9, 32'd2, 32'h00000001, 32'h7FFFFFFC, 1'b0};
      tbl[6] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0};
      tbl[10] = '{2'b10, 32'd7, 32'hFFFFFFFE, 32'd7, 32'd0, 1'b0};
`endif
      tbl[3] = '{2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0};
      tbl[4] = '{2'b11, 32'd47, 32'd7, 32'd5, 32'd6, 1'b0};
      tbl[5] = '{2'b11, 32'd100, 32'd0, 32'd5, 32'd6, 1'b1};
      tbl[7] = '{2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0};
      tbl[8] = '{2'b10, 32'd5, 32'd0, 32'd0, 32'd12, 1'b1};
      tbl[9] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};

      reset = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
      repeat (2) @(negedge clock);
      chk("reset.busy", 64'(busy), 64'd0);
      chk("reset.done", 64'(done), 64'd0);
      chk("reset.div_zero", 64'(div_zero), 64'd0);
      chk("reset.hi", 64'(hi), 64'd0);
      chk("reset.lo", 64'(lo), 64'd0);
      reset = 1'b1;

      for (int i = 0; i < 11; i++) begin
         run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
                tbl[i].ehi, tbl[i].elo, tbl[i].edz, 0);
      end

      // start re-pulsed mid-operation must be ignored
      run_op("repulse", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 5);

      // start held high: one accept every W+2 cycles
      @(negedge clock);
      op = 2'b01; a = 32'd7; b = 32'd9; start = 1'b1;
      nd = 0;
      dc[0] = 0; dc[1] = 0; dc[2] = 0;
      for (int c = 1; c <= 200 && nd < 3; c++) begin
         @(negedge clock);
         if (done === 1'b1) begin
            dc[nd] = c;
            nd++;
            if (nd == 3) start = 1'b0;
         end
      end
      chk("held.done_count", 64'(nd), 64'd3);
      chk("held.first_done", 64'(dc[0]), 64'(W + 1));
      chk("held.spacing1", 64'(dc[1] - dc[0]), 64'(W + 2));
      chk("held.spacing2", 64'(dc[2] - dc[1]), 64'(W + 2));
      chk("held.hi", 64'(hi), 64'd0);
      chk("held.lo", 64'(lo), 64'd63);
      repeat (3) @(negedge clock);

      // asynchronous reset in the middle of a divide
      op = 2'b11; a = 32'd1000; b = 32'd3; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (9) @(negedge clock);
      chk("abort.busy_before", 64'(busy), 64'd1);
      reset = 1'b0;
      #1;
      chk("abort.busy", 64'(busy), 64'd0);
      chk("abort.done", 64'(done), 64'd0);
      chk("abort.hi", 64'(hi), 64'd0);
      chk("abort.lo", 64'(lo), 64'd0);
      @(negedge clock);
      reset = 1'b1;
      exp_hi = '0; exp_lo = '0;
      run_op("after_abort", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 0);

      // randomized operations against the reference model
      for (int i = 0; i < 40; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         case ($urandom_range(0, 5))
            0: rb = '0;
            1: rb = 32'($urandom_range(1, 15));
            2: rb = 32'hFFFFFFFF;
            default: rb = $urandom;
         endcase
         if (i % 8 == 3) ra = 32'h80000000;
         res = ref_model(ro, ra, rb, exp_hi, exp_lo);
         run_op($sformatf("rand%0d", i), ro, ra, rb, res[2*W-1:W], res[W-1:0], res[2*W], 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
